// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the decoupled fetch unit.
// Provides XLEN/ILEN defaults, the NOP encoding and the prefetch queue entry.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            misaligned;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; registered head, no bypass.
// Ports: clk, rst, flush, push/push_data, pop, head, empty, count.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && (count != CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: decoupled IF stage; credit-limited imem requests, in-flight PC
// FIFO, prefetch queue, redirect flush. Optional FETCH_MISALIGN_TRAP_EN.
// Ports: clk, rst, redirect_*, imem_req_*, imem_rsp_*, if_*, fetch_pc.
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              FQ_DEPTH     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus_4,
  output logic [XLEN-1:0] if_instr,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic            if_misaligned,
`endif
  output logic [XLEN-1:0] fetch_pc
);

  import fetch_pkg::*;

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0] FQ_LIM = (CW+1)'(FQ_DEPTH);

  logic [XLEN-1:0] fpc;
  logic [XLEN-1:0] redir_pc;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   qcount;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     credit_use;
  logic            halted;
  logic            trap_pend;
  logic            req_fire;
  logic            rsp_pop;
  logic            rsp_keep;
  logic [XLEN-1:0] rsp_pc;
  logic            q_push;
  logic            q_empty;
  fq_entry_t       q_in;
  fq_entry_t       q_head;
  logic            if_empty_unused;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic redir_misal;

  assign redir_misal = (redirect_pc[1:0] != 2'b00);
  assign redir_pc    = redirect_pc;

  // A misaligned target halts fetch and injects one trap entry the
  // cycle after the redirect, once the queue flush has taken effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      halted    <= 1'b0;
      trap_pend <= 1'b0;
    end else if (redirect_valid) begin
      halted    <= redir_misal;
      trap_pend <= redir_misal;
    end else begin
      trap_pend <= 1'b0;
    end
  end

  assign if_misaligned = !q_empty && q_head.misaligned;
`else
  logic unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];
  assign redir_pc   = {redirect_pc[XLEN-1:2], 2'b00};
  assign halted     = 1'b0;
  assign trap_pend  = 1'b0;
`endif

  // Credits cover both outstanding requests and buffered entries, so a
  // response always has a queue slot.
  assign credit_use     = {1'b0, inflight} + {1'b0, qcount};
  assign imem_req_valid = !rst && !halted && (credit_use < FQ_LIM);
  assign imem_req_addr  = fpc;
  assign fetch_pc       = fpc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing in flight come from before reset; ignore them.
  assign rsp_pop  = imem_rsp_valid && (inflight != '0);
  assign rsp_keep = rsp_pop && (drop_cnt == '0) && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc <= RESET_VECTOR;
    end else if (redirect_valid) begin
      fpc <= redir_pc;
    end else if (req_fire) begin
      fpc <= fpc + XLEN'(4);
    end
  end

  // On redirect everything still in flight after this edge is stale.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (redirect_valid) begin
      drop_cnt <= inflight + CW'(req_fire) - CW'(rsp_pop);
    end else if (rsp_pop && (drop_cnt != '0)) begin
      drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (FQ_DEPTH)
  ) u_inflight (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire),
    .push_data (fpc),
    .pop       (rsp_pop),
    .head      (rsp_pc),
    .empty     (if_empty_unused),
    .count     (inflight)
  );

  always_comb begin
    q_in            = '0;
    q_in.pc         = rsp_pc;
    q_in.instr      = imem_rsp_data;
    q_in.misaligned = 1'b0;
    if (trap_pend) begin
      q_in.pc         = fpc;
      q_in.instr      = '0;
      q_in.misaligned = 1'b1;
    end
  end

  assign q_push = rsp_keep || trap_pend;

  fetch_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (FQ_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_in),
    .pop       (if_ready),
    .head      (q_head),
    .empty     (q_empty),
    .count     (qcount)
  );

  // Outputs read zero while empty; trap entries carry no instruction.
  assign if_valid     = !q_empty;
  assign if_pc        = q_empty ? '0 : q_head.pc;
  assign if_pc_plus_4 = q_empty ? '0 : q_head.pc + XLEN'(4);
  assign if_instr     = (q_empty || q_head.misaligned) ? '0 : q_head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a variable-latency
// in-order memory model; expected fetches queued at request accept.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus_4;
  logic [31:0] if_instr;
  logic [31:0] fetch_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        if_misaligned;
`endif

  fetch_unit #(
    .XLEN         (32),
    .RESET_VECTOR (RV),
    .FQ_DEPTH     (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_pc_plus_4   (if_pc_plus_4),
    .if_instr       (if_instr),
`ifdef FETCH_MISALIGN_TRAP_EN
    .if_misaligned  (if_misaligned),
`endif
    .fetch_pc       (fetch_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } exp_t;

  mreq_t       mem_q[$];
  exp_t        sb[$];
  int          errors;
  int          checks;
  int          cyc;
  int          lat;
  int          accs;
  int          base;
  int          first_acc_cyc;
  int          first_val_cyc;
  logic        track_lat;
  logic        want_first;
  logic        got_first;
  logic [31:0] first_pc;
  logic [31:0] exp_req;
  logic        last_acc;
  logic        last_rsp;
  logic [31:0] snap_addr;
  logic        snap_v;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic mem_drive();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memword(mem_q[0].addr);
      mem_q.delete(0);
    end
  endtask

  task automatic monitor();
    last_acc = imem_req_valid && imem_req_ready;
    last_rsp = imem_rsp_valid;
    if (rst) begin
      sb.delete();
      mem_q.delete();
      exp_req = RV;
      return;
    end
    if (!redirect_valid && if_valid) begin
      if (want_first && !got_first) begin
        first_pc  = if_pc;
        got_first = 1'b1;
      end
      if (track_lat && first_val_cyc < 0) first_val_cyc = cyc;
      if (sb.size() == 0) begin
        check("if_spurious", {31'b0, if_valid}, 32'd0);
      end else begin
        check("if_pc", if_pc, sb[0].pc);
        check("if_pc4", if_pc_plus_4, sb[0].pc + 32'd4);
        check("if_instr", if_instr, sb[0].instr);
`ifdef FETCH_MISALIGN_TRAP_EN
        check("if_mis", {31'b0, if_misaligned}, {31'b0, sb[0].mis});
`endif
        if (if_ready) sb.delete(0);
      end
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_req);
      mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      sb.push_back('{pc: exp_req, instr: memword(exp_req), mis: 1'b0});
      exp_req = exp_req + 32'd4;
      accs++;
      if (track_lat && first_acc_cyc < 0) first_acc_cyc = cyc;
    end
    if (redirect_valid) begin
      sb.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
      exp_req = redirect_pc;
      if (redirect_pc[1:0] != 2'b00)
        sb.push_back('{pc: redirect_pc, instr: 32'h0, mis: 1'b1});
`else
      exp_req = redirect_pc & ~32'd3;
`endif
    end
  endtask

  task automatic cycle();
    mem_drive();
    #1;
    monitor();
    @(negedge clk);
    cyc++;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    want_first     = 1'b1;
    got_first      = 1'b0;
    cycle();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0; checks = 0; cyc = 0; lat = 1; accs = 0;
    first_acc_cyc = -1; first_val_cyc = -1;
    track_lat = 1'b0; want_first = 1'b0; got_first = 1'b0;
    first_pc = '0; exp_req = RV;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; if_ready = 1'b1;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    @(negedge clk);
    cycle();
    cycle();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("rst_if_pc", if_pc, 32'd0);
    check("rst_if_pc4", if_pc_plus_4, 32'd0);
    check("rst_if_instr", if_instr, 32'd0);
    check("rst_fetch_pc", fetch_pc, RV);

    rst = 1'b0;
    track_lat = 1'b1;
    repeat (8) cycle();
    track_lat = 1'b0;
    check("first_latency", first_val_cyc - first_acc_cyc, 32'd2);

    rst = 1'b1;
    cycle();
    rst = 1'b0;
    if_ready = 1'b0;
    base = accs;
    repeat (10) cycle();
    check("credit_accs", accs - base, 32'd4);
    check("credit_block", {31'b0, imem_req_valid}, 32'd0);
    if_ready = 1'b1;
    cycle();
    if_ready = 1'b0;
    repeat (6) cycle();
    check("credit_one", accs - base, 32'd5);
    if_ready = 1'b1;
    repeat (10) cycle();

    lat = 3;
    begin
      int n;
      n = 0;
      while (mem_q.size() < 3 && n < 20) begin
        cycle();
        n++;
      end
      check("l3_inflight", 32'(mem_q.size() >= 3), 32'd1);
    end
    redirect_to(32'h200);
    repeat (14) cycle();
    check("l3_seen", {31'b0, got_first}, 32'd1);
    check("l3_first_pc", first_pc, 32'h200);
    lat = 1;
    repeat (8) cycle();

    redirect_to(32'h300);
    check("rd_acc", {31'b0, last_acc}, 32'd1);
    check("rd_rsp", {31'b0, last_rsp}, 32'd1);
    check("rd_addr", imem_req_addr, 32'h300);
    check("rd_fetch_pc", fetch_pc, 32'h300);
    check("rd_if_valid", {31'b0, if_valid}, 32'd0);
    repeat (8) cycle();
    check("rd_first_pc", first_pc, 32'h300);

    imem_req_ready = 1'b0;
    snap_addr = imem_req_addr;
    snap_v    = imem_req_valid;
    check("stall_v", {31'b0, snap_v}, 32'd1);
    repeat (5) begin
      cycle();
      check("stall_addr", imem_req_addr, snap_addr);
      check("stall_valid", {31'b0, imem_req_valid}, {31'b0, snap_v});
    end
    rst = 1'b1;
    cycle();
    check("mid_rst_if_valid", {31'b0, if_valid}, 32'd0);
    check("mid_rst_fetch_pc", fetch_pc, RV);
    check("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    rst = 1'b0;
    imem_req_ready = 1'b1;
    repeat (6) cycle();

    redirect_to(32'h202);
`ifdef FETCH_MISALIGN_TRAP_EN
    if_ready = 1'b0;
    base = accs;
    check("mis_req_valid", {31'b0, imem_req_valid}, 32'd0);
    repeat (6) cycle();
    check("mis_no_req", accs - base, 32'd0);
    check("mis_if_valid", {31'b0, if_valid}, 32'd1);
    check("mis_if_pc", if_pc, 32'h202);
    check("mis_flag", {31'b0, if_misaligned}, 32'd1);
    if_ready = 1'b1;
    redirect_to(32'h400);
    repeat (8) cycle();
    check("mis_recover_pc", first_pc, 32'h400);
`else
    check("mis_addr", imem_req_addr, 32'h200);
    repeat (8) cycle();
    check("mis_first_pc", first_pc, 32'h200);
`endif

    redirect_to(32'hFFFF_FFF8);
    repeat (10) cycle();
    check("wrap_first_pc", first_pc, 32'hFFFF_FFF8);

    lat = 3;
    repeat (5) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h500;
    cycle();
    redirect_to(32'h600);
    repeat (16) cycle();
    check("b2b_first_pc", first_pc, 32'h600);
    lat = 1;
    repeat (6) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
